// File: rtl/fifo_reader.sv
// Consumer-side drain engine: pops the sample FIFO, captures its registered dataout
// into a 3-entry buffer and presents words on a valid/ready stream. Optional counter: FIFO_READER_COUNT_EN.
module fifo_reader #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dataout,
  output logic             fifo_pop,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] word_count
);

  logic [WIDTH-1:0] mem_q [3];
  logic [WIDTH-1:0] mem_d [3];
  logic [1:0]       rd_q, rd_d;
  logic [1:0]       wr_q, wr_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic             capture_s;
  logic             drain_s;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    if (p == 2'd2) begin
      return 2'd0;
    end else begin
      return p + 2'd1;
    end
  endfunction

  // Pop request: occupancy plus the in-flight word must leave room; m_ready is deliberately absent
  always_comb begin
    fifo_pop = 1'b0;
    if (reset && !flush && !fifo_empty &&
        (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3)) begin
      fifo_pop = 1'b1;
    end else begin
      fifo_pop = 1'b0;
    end
  end

  // Stream head presentation
  always_comb begin
    m_valid = (occ_q != 2'd0);
    case (rd_q)
      2'd0:    m_data = mem_q[0];
      2'd1:    m_data = mem_q[1];
      2'd2:    m_data = mem_q[2];
      default: m_data = {WIDTH{1'b0}};
    endcase
  end

  // Next-state: flush overrides capture, drain and pop
  always_comb begin
    capture_s  = inflight_q && !flush;
    drain_s    = (occ_q != 2'd0) && m_ready && !flush;
    rd_d       = rd_q;
    wr_d       = wr_q;
    occ_d      = occ_q;
    inflight_d = fifo_pop;
    for (int i = 0; i < 3; i++) begin
      if (capture_s && (wr_q == 2'(i))) begin
        mem_d[i] = fifo_dataout;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
    if (flush) begin
      rd_d  = 2'd0;
      wr_d  = 2'd0;
      occ_d = 2'd0;
    end else begin
      if (capture_s) begin
        wr_d = ptr_inc(wr_q);
      end else begin
        wr_d = wr_q;
      end
      if (drain_s) begin
        rd_d = ptr_inc(rd_q);
      end else begin
        rd_d = rd_q;
      end
      case ({capture_s, drain_s})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      rd_q       <= 2'd0;
      wr_q       <= 2'd0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef FIFO_READER_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Delivered-word counter; survives flush, cleared only by reset
  always_comb begin
    cnt_d = cnt_q;
    if (drain_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign word_count = cnt_q;
`else
  assign word_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: FIFO model plus a scoreboard of popped-but-undelivered words.
module tb_fifo_reader;
  localparam int WIDTH = 24;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_dataout;
  logic             fifo_pop;
  logic             flush;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [CNT_W-1:0] word_count;

  fifo_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_dataout(fifo_dataout),
    .fifo_pop(fifo_pop), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Source FIFO model: registered dataout one cycle after an accepted pop
  logic [WIDTH-1:0] fifo_mem [0:1023];
  int fifo_head = 0;
  int fifo_tail = 0;
  assign fifo_empty = (fifo_head == fifo_tail);

  always @(posedge clk) begin
    if (fifo_pop && !fifo_empty) begin
      fifo_dataout <= fifo_mem[fifo_head[9:0]];
      fifo_head    <= fifo_head + 1;
    end
  end

  // Reference model: every popped word is owed downstream, in order, unless flushed/reset
  logic [WIDTH-1:0] exp_q [$];
  bit               last_pop = 1'b0;
  int               exp_cnt = 0;
  int               errors = 0;
  int               checks = 0;
  int               pops = 0;
  int               drains = 0;
  logic [WIDTH-1:0] last_word = '0;
  logic             obs_pop, obs_valid;
  logic [7:0]       fp, mv;
  int               p0, d0;

  function automatic logic [31:0] exp_wc();
`ifdef FIFO_READER_COUNT_EN
    return 32'(exp_cnt & ((1 << CNT_W) - 1));
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] v);
    fifo_mem[fifo_tail[9:0]] = v;
    fifo_tail = fifo_tail + 1;
  endtask

  task automatic cycle();
    logic             exp_pop, exp_valid, kill, did_drain;
    logic [WIDTH-1:0] pw;
    #1;
    exp_pop   = reset && !flush && !fifo_empty && (exp_q.size() < 3);
    exp_valid = (exp_q.size() - (last_pop ? 1 : 0)) > 0;
    obs_pop   = fifo_pop;
    obs_valid = m_valid;
    chk("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
    chk("m_valid", 32'(m_valid), 32'(exp_valid));
    if (exp_valid) chk("m_data", 32'(m_data), 32'(exp_q[0]));
    chk("word_count", 32'(word_count), exp_wc());
    kill      = !reset || flush;
    did_drain = exp_valid && m_ready && !kill;
    pw        = fifo_mem[fifo_head[9:0]];
    @(posedge clk);
    if (kill) begin
      exp_q.delete();
      last_pop = 1'b0;
      if (!reset) exp_cnt = 0;
    end else begin
      if (did_drain) begin
        last_word = exp_q.pop_front();
        exp_cnt++;
        drains++;
      end
      if (exp_pop) begin
        exp_q.push_back(pw);
        pops++;
      end
      last_pop = exp_pop;
    end
    @(negedge clk);
  endtask

  initial begin
    reset   = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    cycle();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    reset = 1'b1;

    // Streaming with m_ready high: 4 back-to-back pops, output 2 cycles later
    for (int i = 1; i <= 4; i++) push(WIDTH'(i));
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      fp[i] = obs_pop;
      mv[i] = obs_valid;
    end
    chk("t1_pop_pattern", 32'(fp), 32'h0F);
    chk("t1_valid_pattern", 32'(mv), 32'h3C);
    chk("t1_last", 32'(last_word), 32'h4);

    // Backpressure: at most three pops while stalled
    m_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 6; i++) push(WIDTH'(32'hA0 + i));
    for (int i = 0; i < 6; i++) cycle();
    chk("t2_pops_stalled", 32'(pops - p0), 32'd3);
    chk("t2_pop_low", 32'(obs_pop), 32'd0);
    m_ready = 1'b1;
    d0 = drains;
    for (int i = 0; i < 12; i++) cycle();
    chk("t2_drained", 32'(drains - d0), 32'd6);
    chk("t2_last", 32'(last_word), 32'hA5);

    // Alternating ready
    d0 = drains;
    for (int i = 0; i < 8; i++) push(WIDTH'(32'h10 + i));
    for (int i = 0; i < 30; i++) begin
      m_ready = (i % 2 == 0);
      cycle();
    end
    chk("t3_drained", 32'(drains - d0), 32'd8);
    chk("t3_last", 32'(last_word), 32'h17);

    // Flush with two buffered words and one in flight
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(WIDTH'(32'h30 + i));
    for (int i = 0; i < 3; i++) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    push(WIDTH'(32'h55));
    m_ready = 1'b1;
    d0 = drains;
    cycle();
    chk("t4_valid_after_flush", 32'(obs_valid), 32'd0);
    for (int i = 0; i < 6; i++) cycle();
    chk("t4_drained", 32'(drains - d0), 32'd1);
    chk("t4_first_after_flush", 32'(last_word), 32'h55);

    // Reset pulse mid-stream, then clean restart
    for (int i = 0; i < 12; i++) push(WIDTH'(32'h60 + i));
    for (int i = 0; i < 5; i++) cycle();
    reset = 1'b0;
    cycle();
    chk("t5_pop_in_reset", 32'(obs_pop), 32'd0);
    reset = 1'b1;
    chk("t5_m_valid", 32'(m_valid), 32'd0);
    chk("t5_m_data", 32'(m_data), 32'd0);
    chk("t5_word_count", 32'(word_count), 32'd0);
    for (int i = 0; i < 20; i++) cycle();
    chk("t5_last", 32'(last_word), 32'h6B);

    // Randomized traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0 && (fifo_tail - fifo_head) < 8) push(WIDTH'($urandom));
      m_ready = 1'($urandom_range(0, 1));
      flush   = ($urandom_range(0, 19) == 0);
      cycle();
    end
    flush   = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 30; i++) cycle();
    chk("rand_fifo_drained", 32'(fifo_empty), 32'd1);

    // Counter wrap: 17 deliveries after reset
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    d0 = drains;
    for (int i = 0; i < 17; i++) push(WIDTH'(32'h100 + i));
    for (int i = 0; i < 25; i++) cycle();
    chk("t6_drained", 32'(drains - d0), 32'd17);
`ifdef FIFO_READER_COUNT_EN
    chk("t6_word_count", 32'(word_count), 32'd1);
`else
    chk("t6_word_count", 32'(word_count), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
